// File: rtl/rx_timer_pkg.sv
// Shared types and default timing for the RX bit timer.
// Optional feature macro: RX_BIT_TIMER_RESYNC_EN (realign phase on edges in RUN).
package rx_timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RUN
   } rx_timer_state_t;

   localparam int RX_CLKS_PER_BIT  = 8;
   localparam int RX_SAMPLE_POINT  = 3;
   localparam int RX_BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// Counter with clear, load, count-enable and a programmable rollover value.
// Priority: clear, then load, then count.
module flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             count_en_i,
   input  logic [WIDTH-1:0] rollover_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: explicit wrap compare, never relies on 2^N rollover
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (count_en_i) begin
         if (count_q == rollover_i) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // count register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/rx_bit_timer.sv
// RX bit timer: locks on the first edge, strobes mid-bit, counts bits.
// Optional feature macro: RX_BIT_TIMER_RESYNC_EN (edges in RUN reset phase to 1).
module rx_bit_timer
   import rx_timer_pkg::*;
#(
   parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT,
   parameter int SAMPLE_POINT  = RX_SAMPLE_POINT,
   parameter int BITS_PER_BYTE = RX_BITS_PER_BYTE
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             enable_i,
   input  logic                             edge_found_i,
   output logic                             shift_strobe_o,
   output logic                             byte_done_o,
   output logic [$clog2(BITS_PER_BYTE)-1:0] bit_count_o,
   output logic                             locked_o
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(BITS_PER_BYTE);

   localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
   localparam logic [PW-1:0] PH_ONE    = PW'(1);
   localparam logic [BW-1:0] BC_LAST   = BW'(BITS_PER_BYTE - 1);
   localparam logic [BW-1:0] BC_ZERO   = '0;

   rx_timer_state_t state_q;
   rx_timer_state_t state_d;

   logic [PW-1:0] phase;
   logic [BW-1:0] bit_count;

   logic clr;
   logic phase_load;
   logic phase_run;
   logic strobe;
   logic byte_done;

   // state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state, counter controls and strobes
   always_comb begin
      state_d    = state_q;
      clr        = 1'b0;
      phase_load = 1'b0;
      strobe     = 1'b0;
      byte_done  = 1'b0;
      unique case (state_q)
         IDLE: begin
            clr = 1'b1;
            if (enable_i) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (!enable_i) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else if (edge_found_i) begin
               // edge cycle is phase 0, so next is 1
               state_d    = RUN;
               phase_load = 1'b1;
            end
         end
         RUN: begin
            if (!enable_i) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else begin
               strobe    = (phase == PH_SAMPLE);
               byte_done = strobe && (bit_count == BC_LAST);
`ifdef RX_BIT_TIMER_RESYNC_EN
               phase_load = edge_found_i;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            clr     = 1'b1;
         end
      endcase
   end

   assign phase_run = (state_q == RUN);

   flex_counter #(
      .WIDTH(PW)
   ) u_phase (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear_i   (clr),
      .load_i    (phase_load),
      .load_val_i(PH_ONE),
      .count_en_i(phase_run),
      .rollover_i(PH_LAST),
      .count_o   (phase)
   );

   flex_counter #(
      .WIDTH(BW)
   ) u_bit_count (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear_i   (clr),
      .load_i    (1'b0),
      .load_val_i(BC_ZERO),
      .count_en_i(strobe),
      .rollover_i(BC_LAST),
      .count_o   (bit_count)
   );

   assign shift_strobe_o = strobe;
   assign byte_done_o    = byte_done;
   assign bit_count_o    = bit_count;
   assign locked_o       = phase_run;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer (defaults 8/3/8).
// Expectations follow RX_BIT_TIMER_RESYNC_EN when it is defined.
module tb_rx_bit_timer;
   import rx_timer_pkg::*;

   localparam int CPB = 8;
   localparam int BPB = 8;
   localparam int BW  = $clog2(BPB);

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          enable_i = 1'b0;
   logic          edge_found_i = 1'b0;
   logic          shift_strobe_o;
   logic          byte_done_o;
   logic [BW-1:0] bit_count_o;
   logic          locked_o;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      int cyc;
      int done;
      int cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;

   rx_bit_timer dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .enable_i      (enable_i),
      .edge_found_i  (edge_found_i),
      .shift_strobe_o(shift_strobe_o),
      .byte_done_o   (byte_done_o),
      .bit_count_o   (bit_count_o),
      .locked_o      (locked_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string nm, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) step();
   endtask

   task automatic push(int c, int cnt);
      exp_t x;
      x.cyc  = c;
      x.cnt  = cnt;
      x.done = (cnt == BPB - 1) ? 1 : 0;
      q.push_back(x);
   endtask

   task automatic pulse_edge();
      edge_found_i = 1'b1;
      step();
      edge_found_i = 1'b0;
   endtask

   // monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (n_rst) begin
         if (shift_strobe_o) begin
            if (q.size() == 0) begin
               check("unexpected_strobe", int'(shift_strobe_o), 0);
            end else begin
               e = q.pop_front();
               check("strobe_cycle", cyc, e.cyc);
               check("byte_done", int'(byte_done_o), e.done);
               check("bit_count_at_strobe", int'(bit_count_o), e.cnt);
            end
         end else begin
            check("byte_done_no_strobe", int'(byte_done_o), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      int s;
      int nxt;

      // reset state
      step();
      step();
      check("rst_locked", int'(locked_o), 0);
      check("rst_strobe", int'(shift_strobe_o), 0);
      check("rst_byte_done", int'(byte_done_o), 0);
      check("rst_bit_count", int'(bit_count_o), 0);
      n_rst = 1'b1;
      step();

      // edges while disabled are ignored
      pulse_edge();
      step();
      check("idle_state", int'(dut.state_q), int'(IDLE));
      check("idle_locked", int'(locked_o), 0);
      check("idle_bit_count", int'(bit_count_o), 0);

      // run A: full byte, then drop enable on a strobe cycle
      enable_i = 1'b1;
      step();
      step();
      check("sync_state", int'(dut.state_q), int'(SYNC));
      check("sync_locked", int'(locked_o), 0);
      t = cyc;
      for (int i = 0; i < BPB; i++) push(t + 3 + i * CPB, i);
      push(t + 67, 0);
      pulse_edge();
      check("locked_t1", int'(locked_o), 1);
      wait_until(t + 12);
      check("bit_count_t12", int'(bit_count_o), 2);
      wait_until(t + 60);
      check("bit_count_wrap", int'(bit_count_o), 0);
      check("pending_a", q.size(), 1);
      wait_until(t + 68);
      check("bit_count_t68", int'(bit_count_o), 1);
      wait_until(t + 75);
      enable_i = 1'b0;
      step();
      check("drop_state", int'(dut.state_q), int'(IDLE));
      check("drop_locked", int'(locked_o), 0);
      check("drop_bit_count", int'(bit_count_o), 0);
      check("drained_a", q.size(), 0);

      // re-enable waits in SYNC for a new edge
      enable_i = 1'b1;
      step();
      step();
      step();
      step();
      check("resync_wait_state", int'(dut.state_q), int'(SYNC));
      check("resync_wait_locked", int'(locked_o), 0);

      // run B: mid-bit edge, then edge coincident with a strobe
      t = cyc;
      push(t + 3, 0);
      push(t + 11, 1);
      pulse_edge();
      wait_until(t + 13);
`ifdef RX_BIT_TIMER_RESYNC_EN
      push(t + 16, 2);
      push(t + 24, 3);
      s = t + 24;
      nxt = s + 3;
`else
      push(t + 19, 2);
      push(t + 27, 3);
      s = t + 27;
      nxt = s + 8;
`endif
      pulse_edge();
      wait_until(s);
      push(nxt, 4);
      pulse_edge();
      wait_until(s + 9);
      check("drained_b", q.size(), 0);
      check("bit_count_b", int'(bit_count_o), 5);
      check("locked_b", int'(locked_o), 1);

      // asynchronous reset in the middle of a cycle
      #2;
      n_rst = 1'b0;
      #1;
      check("arst_locked", int'(locked_o), 0);
      check("arst_bit_count", int'(bit_count_o), 0);
      check("arst_strobe", int'(shift_strobe_o), 0);
      check("arst_state", int'(dut.state_q), int'(IDLE));
      step();
      n_rst = 1'b1;
      step();
      step();
      check("post_rst_state", int'(dut.state_q), int'(SYNC));
      enable_i = 1'b0;
      step();
      step();
      check("final_state", int'(dut.state_q), int'(IDLE));
      check("final_pending", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
